// File: rtl/uart_timing_pkg.sv
// Shared constants and elaboration helpers for the UART timing front-end.
package uart_timing_pkg;

  localparam int unsigned NUM_BAUD = 5;

  // Selectable baud rates in Hz, indexed by BAUD_SEL.
  localparam int unsigned BAUD_TABLE [NUM_BAUD] = '{9600, 19200, 38400, 57600, 115200};

  // Bits needed for a counter running 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // x8 oversample divisor, rounded to nearest. Returns 0 for an illegal
  // select so the caller's range check fires instead of an index fault.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned sel);
    int unsigned baud;
    if (sel >= NUM_BAUD) return 0;
    baud = BAUD_TABLE[sel[2:0]];
    return (clk_freq + 4 * baud) / (8 * baud);
  endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// Tick-sampled edge detector: level_in is sampled only on tick, so any
// glitch that misses a sample is invisible. Pulses line up with the tick.
// Optional falling-edge output is enabled by UART_TIMING_FALL_EDGE_EN.
module tick_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic level_in,
    output logic rise_pulse
`ifdef UART_TIMING_FALL_EDGE_EN
   ,output logic fall_pulse
`endif
  );

  logic s0_q, s1_q, rise_q;

  // Two-deep sample history advanced on tick; pulse uses pre-update samples.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s0_q   <= 1'b0;
      s1_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      rise_q <= tick & s0_q & ~s1_q;
      if (tick) begin
        s0_q <= level_in;
        s1_q <= s0_q;
      end
    end
  end

  assign rise_pulse = rise_q;

`ifdef UART_TIMING_FALL_EDGE_EN
  logic fall_q;

  // Mirror of the rise detector for a sampled 1->0 transition.
  always_ff @(posedge clk) begin
    if (!rst) fall_q <= 1'b0;
    else      fall_q <= tick & ~s0_q & s1_q;
  end

  assign fall_pulse = fall_q;
`endif

endmodule

// File: rtl/uart_timing_gen.sv
// UART transmit-path timing front-end: slow tick divider, 8x/1x baud
// strobes and a tick-sampled edge detector. All outputs are one-cycle
// clock enables in the clk domain.
// Optional: define UART_TIMING_FALL_EDGE_EN to add the fall_pulse output.
module uart_timing_gen
  import uart_timing_pkg::*;
#(
    parameter int unsigned CLK_FREQ       = 100_000_000,
    parameter int unsigned CLK_DIV_CYCLES = 100_000,
    parameter int unsigned BAUD_SEL       = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic baud_en,
    input  logic level_in,
    output logic slow_tick,
    output logic bclk_x8,
    output logic bclk,
    output logic rise_pulse
`ifdef UART_TIMING_FALL_EDGE_EN
   ,output logic fall_pulse
`endif
  );

  localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD_SEL);
  localparam int unsigned SW  = cnt_width(CLK_DIV_CYCLES);
  localparam int unsigned BW  = cnt_width(DIV);

  if (BAUD_SEL >= NUM_BAUD) begin : g_bad_baud_sel
    $error("uart_timing_gen: BAUD_SEL out of range");
  end
  if (DIV < 2) begin : g_bad_div
    $error("uart_timing_gen: baud divisor below 2");
  end
  if (CLK_DIV_CYCLES < 2) begin : g_bad_clk_div
    $error("uart_timing_gen: CLK_DIV_CYCLES below 2");
  end

  // ---------------- slow divider ----------------
  logic [SW-1:0] div_cnt_q, div_cnt_d;
  logic          slow_tick_q;
  logic          tick;

  assign tick = (div_cnt_q == SW'(CLK_DIV_CYCLES - 1));

  // Free-running 0..CLK_DIV_CYCLES-1 counter.
  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (tick) div_cnt_d = '0;
  end

  // Divider state and the registered tick strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt_q   <= '0;
      slow_tick_q <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      slow_tick_q <= tick;
    end
  end

  // ---------------- baud strobes ----------------
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [2:0]    phase_q, phase_d;
  logic          x8_wrap;
  logic          bclk_x8_q, bclk_q;

  assign x8_wrap = baud_en & (bcnt_q == BW'(DIV - 1));

  // baud_en low parks both counters at zero so a re-enable starts a fresh
  // 8*DIV frame; the phase counter picks every 8th x8 wrap for bclk.
  always_comb begin
    bcnt_d  = bcnt_q + 1'b1;
    phase_d = phase_q;
    if (x8_wrap) begin
      bcnt_d  = '0;
      phase_d = phase_q + 3'd1;
    end
    if (!baud_en) begin
      bcnt_d  = '0;
      phase_d = '0;
    end
  end

  // Baud counters and their registered strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bcnt_q    <= '0;
      phase_q   <= '0;
      bclk_x8_q <= 1'b0;
      bclk_q    <= 1'b0;
    end else begin
      bcnt_q    <= bcnt_d;
      phase_q   <= phase_d;
      bclk_x8_q <= x8_wrap;
      bclk_q    <= x8_wrap & (phase_q == 3'd7);
    end
  end

  // ---------------- edge detector ----------------
  tick_edge_detect u_edge (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .level_in   (level_in),
    .rise_pulse (rise_pulse)
`ifdef UART_TIMING_FALL_EDGE_EN
   ,.fall_pulse (fall_pulse)
`endif
  );

  assign slow_tick = slow_tick_q;
  assign bclk_x8   = bclk_x8_q;
  assign bclk      = bclk_q;

endmodule

// File: tb/tb_uart_timing_gen.sv
// Directed bench for uart_timing_gen with CLK_FREQ=768000, BAUD_SEL=0
// (DIV=10) and CLK_DIV_CYCLES=4. Cycle n counts clock edges after reset
// release; expected strobe cycles are written out by hand per segment.
module tb_uart_timing_gen;

  logic clk = 1'b0;
  logic rst, baud_en, level_in;
  logic slow_tick, bclk_x8, bclk, rise_pulse;
`ifdef UART_TIMING_FALL_EDGE_EN
  logic fall_pulse;
`endif

  int vectors    = 0;
  int miscompares = 0;
  int cur_n      = 0;

  always #5 clk = ~clk;

  uart_timing_gen #(
    .CLK_FREQ       (768_000),
    .CLK_DIV_CYCLES (4),
    .BAUD_SEL       (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_en    (baud_en),
    .level_in   (level_in),
    .slow_tick  (slow_tick),
    .bclk_x8    (bclk_x8),
    .bclk       (bclk),
    .rise_pulse (rise_pulse)
`ifdef UART_TIMING_FALL_EDGE_EN
   ,.fall_pulse (fall_pulse)
`endif
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle=%0d got=%b exp=%b", tag, cur_n, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic in_rst;
    int   k, r;
    logic e_tick, e_x8, e_bclk, e_rise, e_fall;

    rst = 1'b0; baud_en = 1'b0; level_in = 1'b0;

    // Reset held for 5 cycles: every output must be low.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_slow_tick", slow_tick, 1'b0);
      chk("rst_bclk_x8",   bclk_x8,   1'b0);
      chk("rst_bclk",      bclk,      1'b0);
      chk("rst_rise",      rise_pulse, 1'b0);
`ifdef UART_TIMING_FALL_EDGE_EN
      chk("rst_fall",      fall_pulse, 1'b0);
`endif
    end

    // Schedule (inputs seen at edge n):
    //   baud_en low at 35..37, reset low at 196..197 (one before bclk at 197)
    //   level high 22..45 (rise at tick 28, fall at tick 52),
    //   glitch 62..63 (between ticks 60/64, ignored), high again from 189
    //   (rise would land at 196, killed by reset; re-detected at 205).
    for (int n = 1; n <= 285; n++) begin
      rst      = !(n == 196 || n == 197);
      baud_en  = !(n >= 35 && n <= 37);
      level_in = (n >= 22 && n <= 45) || (n >= 62 && n <= 63) || (n >= 189);
      cur_n    = n;
      step();

      in_rst = (n == 196 || n == 197);
      k      = (n < 196) ? n : n - 197;
      e_tick = !in_rst && (k % 4 == 0);
      if (in_rst || (n >= 35 && n <= 37)) begin
        e_x8 = 1'b0; e_bclk = 1'b0;
      end else if (n <= 34) begin
        e_x8 = (n % 10 == 0); e_bclk = (n % 80 == 0);
      end else if (n < 196) begin
        r = n - 37;
        e_x8 = (r % 10 == 0); e_bclk = (r % 80 == 0);
      end else begin
        e_x8 = (k % 10 == 0); e_bclk = (k % 80 == 0);
      end
      e_rise = (n == 28) || (n == 205);
      e_fall = (n == 52);

      chk("slow_tick",  slow_tick,  e_tick);
      chk("bclk_x8",    bclk_x8,    e_x8);
      chk("bclk",       bclk,       e_bclk);
      chk("rise_pulse", rise_pulse, e_rise);
`ifdef UART_TIMING_FALL_EDGE_EN
      chk("fall_pulse", fall_pulse, e_fall);
`else
      if (e_fall) chk("rise_on_fall", rise_pulse, 1'b0);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
